// File: rtl/wrrn_arbit_if.sv
// rtl/wrrn_arbit_if.sv - request/weight/grant bundle for the N-way WRR arbiter
//
// Signals:
//   req      per-channel request level
//   wt       packed weights, channel i at wt[i*WT_W +: WT_W]
//   sp_mode  1 = strict priority (lowest index wins), 0 = weighted round-robin
//   gnt_rdy  downstream accepts the current grant
//   gnt_vld  registered grant valid
//   gnt      registered one-hot grant, zero when gnt_vld=0
//   gnt_idx  binary index of gnt, zero when gnt_vld=0
// Modports: master = requester/downstream side, slave = arbiter.
interface wrrn_arbit_if #(
    parameter int N    = 4,
    parameter int WT_W = 5
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]      req;
    logic [N*WT_W-1:0] wt;
    logic              sp_mode;
    logic              gnt_rdy;
    logic              gnt_vld;
    logic [N-1:0]      gnt;
    logic [IDX_W-1:0]  gnt_idx;

    modport master (
        output req, wt, sp_mode, gnt_rdy,
        input  gnt_vld, gnt, gnt_idx
    );

    modport slave (
        input  req, wt, sp_mode, gnt_rdy,
        output gnt_vld, gnt, gnt_idx
    );
endinterface

// File: rtl/wrrn_arbit.sv
// rtl/wrrn_arbit.sv - N-way weighted round-robin arbiter with registered grant
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   arb    wrrn_arbit_if.slave: req/wt/sp_mode/gnt_rdy in, gnt_vld/gnt/gnt_idx out
// The holder (last granted channel) keeps the grant for wt consecutive units
// while it stays eligible; otherwise the search rotates starting after it.
module wrrn_arbit #(
    parameter int N    = 4,
    parameter int WT_W = 5,
    localparam int IDX_W = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst_n,
    wrrn_arbit_if.slave arb
);
    logic              r_gnt_vld;
    logic [N-1:0]      r_gnt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [IDX_W-1:0]  r_hold;
    logic              r_hold_vld;
    logic [WT_W-1:0]   r_wt_left;

    logic [N-1:0]      w_elig;
    logic              w_slot_free;
    logic              w_cont;
    logic [IDX_W-1:0]  w_start;
    logic              w_rot_found;
    logic [IDX_W-1:0]  w_rot_idx;
    logic [WT_W-1:0]   w_rot_wt;
    logic              w_sp_found;
    logic [IDX_W-1:0]  w_sp_idx;

    logic              w_nxt_vld;
    logic [IDX_W-1:0]  w_nxt_idx;
    logic [N-1:0]      w_nxt_gnt;
    logic [IDX_W-1:0]  w_nxt_hold;
    logic              w_nxt_hold_vld;
    logic [WT_W-1:0]   w_nxt_wt_left;

    assign w_slot_free = !r_gnt_vld || arb.gnt_rdy;

    // In strict-priority mode weights are ignored, so a zero weight does not mask.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = arb.req[i] && (arb.sp_mode || (arb.wt[i*WT_W +: WT_W] != '0));
        end
    end

    assign w_cont = r_hold_vld && w_elig[r_hold] && (r_wt_left != '0);

    // Search starts one past the holder, so the holder itself is considered last.
    assign w_start = !r_hold_vld ? '0 :
                     (r_hold == IDX_W'(N-1)) ? '0 : r_hold + 1'b1;

    // Walk the ring backwards so the candidate closest to w_start is kept.
    always_comb begin
        int c;
        c           = 0;
        w_rot_found = 1'b0;
        w_rot_idx   = '0;
        for (int k = N-1; k >= 0; k--) begin
            c = int'(w_start) + k;
            if (c >= N) c = c - N;
            if (w_elig[c]) begin
                w_rot_found = 1'b1;
                w_rot_idx   = IDX_W'(c);
            end
        end
    end

    assign w_rot_wt = arb.wt[w_rot_idx*WT_W +: WT_W];

    always_comb begin
        w_sp_found = 1'b0;
        w_sp_idx   = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (arb.req[i]) begin
                w_sp_found = 1'b1;
                w_sp_idx   = IDX_W'(i);
            end
        end
    end

    // Without a free slot every default holds the current state (stall).
    always_comb begin
        w_nxt_vld      = r_gnt_vld;
        w_nxt_idx      = r_gnt_idx;
        w_nxt_hold     = r_hold;
        w_nxt_hold_vld = r_hold_vld;
        w_nxt_wt_left  = r_wt_left;
        if (w_slot_free) begin
            if (arb.sp_mode) begin
                if (w_sp_found) begin
                    w_nxt_vld      = 1'b1;
                    w_nxt_idx      = w_sp_idx;
                    w_nxt_hold     = w_sp_idx;
                    w_nxt_hold_vld = 1'b1;
                    w_nxt_wt_left  = '0;
                end else begin
                    w_nxt_vld = 1'b0;
                    w_nxt_idx = '0;
                end
            end else if (w_cont) begin
                w_nxt_vld     = 1'b1;
                w_nxt_idx     = r_hold;
                w_nxt_wt_left = r_wt_left - 1'b1;
            end else if (w_rot_found) begin
                w_nxt_vld      = 1'b1;
                w_nxt_idx      = w_rot_idx;
                w_nxt_hold     = w_rot_idx;
                w_nxt_hold_vld = 1'b1;
                w_nxt_wt_left  = w_rot_wt - 1'b1;
            end else begin
                w_nxt_vld = 1'b0;
                w_nxt_idx = '0;
            end
        end
    end

    always_comb begin
        w_nxt_gnt = '0;
        for (int i = 0; i < N; i++) begin
            w_nxt_gnt[i] = w_nxt_vld && (w_nxt_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_vld  <= 1'b0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_wt_left  <= '0;
        end else begin
            r_gnt_vld  <= w_nxt_vld;
            r_gnt      <= w_nxt_gnt;
            r_gnt_idx  <= w_nxt_idx;
            r_hold     <= w_nxt_hold;
            r_hold_vld <= w_nxt_hold_vld;
            r_wt_left  <= w_nxt_wt_left;
        end
    end

    assign arb.gnt_vld = r_gnt_vld;
    assign arb.gnt     = r_gnt;
    assign arb.gnt_idx = r_gnt_idx;
endmodule
